// File: rtl/code_reverse_converter.sv
// Multi-cycle decoder: restores a binary value from Gray, packed-BCD or excess-3.
// Gray is decoded MSB-first one bit per cycle; BCD/excess-3 use reverse double-dabble.
module code_reverse_converter #(
  parameter int N = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     sel,
  input  logic [4*D-1:0] din,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   dout,
  output logic           err,
  output logic [1:0]     state
);

  localparam int W  = 4 * D;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] SEL_PASS = 2'b00;
  localparam logic [1:0] SEL_GRAY = 2'b01;
  localparam logic [1:0] SEL_BCD  = 2'b10;
  localparam logic [1:0] SEL_XS3  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sel_q;
  logic [W-1:0]    din_q;
  logic [W-1:0]    bcd_q;
  logic [N-1:0]    bin_q;
  logic [N-1:0]    gray_q;
  logic            run_q;
  logic [CW-1:0]   cnt_q;

  logic            bcd_ok;
  logic            xs3_ok;
  logic            load_err;
  logic [W-1:0]    xs3_adj;
  logic [W+N-1:0]  shifted;
  logic [3:0]      digit;
  logic [W-1:0]    bcd_step;
  logic [N-1:0]    bin_step;
  logic            gray_bit;
  logic [N-1:0]    gray_bin;
  logic            last;

  // Digit validation, excess-3 bias removal and one reverse double-dabble step.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    bcd_ok   = 1'b1;
    xs3_ok   = 1'b1;
    xs3_adj  = '0;
    bcd_step = '0;
    digit    = '0;
    shifted  = {bcd_q, bin_q} >> 1;
    for (int i = 0; i < D; i++) begin
      if (din_q[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
      if (din_q[4*i +: 4] < 4'd3 || din_q[4*i +: 4] > 4'd12) xs3_ok = 1'b0;
      xs3_adj[4*i +: 4] = din_q[4*i +: 4] - 4'd3;
      digit = shifted[N + 4*i +: 4];
      bcd_step[4*i +: 4] = (digit >= 4'd8) ? digit - 4'd3 : digit;
    end
  end

  assign bin_step = shifted[N-1:0];
  assign gray_bit = run_q ^ gray_q[N-1];
  assign gray_bin = {bin_q[N-2:0], gray_bit};
  assign last     = (cnt_q == CW'(1));
  assign load_err = (sel_q == SEL_BCD && !bcd_ok) || (sel_q == SEL_XS3 && !xs3_ok);

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign state = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: state_d = (sel_q == SEL_PASS || load_err) ? DONE : CONV;
      CONV: state_d = last ? DONE : CONV;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered results. dout/err change only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all datapath registers are cleared on reset so an aborted operation leaves no residue.
    if (rst) begin
      sel_q  <= '0;
      din_q  <= '0;
      bcd_q  <= '0;
      bin_q  <= '0;
      gray_q <= '0;
      run_q  <= 1'b0;
      cnt_q  <= '0;
      dout   <= '0;
      err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          if (start) begin
            sel_q <= sel;
            din_q <= din;
          end
        end
        LOAD: begin
          case (sel_q)
            SEL_PASS: begin
              dout <= din_q[N-1:0];
              err  <= 1'b0;
            end
            SEL_GRAY: begin
              gray_q <= din_q[N-1:0];
              run_q  <= 1'b0;
              bin_q  <= '0;
              cnt_q  <= CW'(N);
            end
            default: begin
              if (load_err) begin
                dout <= '0;
                err  <= 1'b1;
              end else begin
                bcd_q <= (sel_q == SEL_BCD) ? din_q : xs3_adj;
                bin_q <= '0;
                cnt_q <= CW'(N);
              end
            end
          endcase
        end
        CONV: begin
          cnt_q <= cnt_q - CW'(1);
          if (sel_q == SEL_GRAY) begin
            gray_q <= gray_q << 1;
            run_q  <= gray_bit;
            bin_q  <= gray_bin;
            if (last) begin
              dout <= gray_bin;
              err  <= 1'b0;
            end
          end else begin
            bcd_q <= bcd_step;
            bin_q <= bin_step;
            // Residual BCD after N shifts means the value does not fit in N bits.
            if (last) begin
              if (bcd_step != '0) begin
                dout <= '0;
                err  <= 1'b1;
              end else begin
                dout <= bin_step;
                err  <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_code_reverse_converter.sv
// Scoreboard bench for code_reverse_converter: expected results are derived from
// decimal/Gray arithmetic and checked by an independent monitor on each done pulse.
module tb_code_reverse_converter;

  localparam int N = 8;
  localparam int D = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     sel = '0;
  logic [4*D-1:0] din = '0;
  logic           busy;
  logic           done;
  logic [N-1:0]   dout;
  logic           err;
  logic [1:0]     state;

  code_reverse_converter #(.N(N), .D(D)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .din(din),
    .busy(busy), .done(done), .dout(dout), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] dout;
    logic         err;
    int           lat;
    int           cap;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: decode by plain arithmetic on decimal digits / prefix XOR.
  function automatic exp_t model(input logic [1:0] s, input logic [4*D-1:0] d, input int cap);
    exp_t r;
    int value;
    int dig;
    bit bad;
    logic [N-1:0] g, b;
    r.cap = cap;
    r.err = 1'b0;
    r.dout = '0;
    r.lat = N + 2;
    case (s)
      2'b00: begin
        r.dout = d[N-1:0];
        r.lat = 2;
      end
      2'b01: begin
        g = d[N-1:0];
        b = g;
        for (int k = 1; k < N; k++) b = b ^ (g >> k);
        r.dout = b;
      end
      default: begin
        value = 0;
        bad = 1'b0;
        for (int k = D - 1; k >= 0; k--) begin
          dig = int'(d[4*k +: 4]);
          if (s == 2'b11) begin
            if (dig < 3 || dig > 12) bad = 1'b1;
            dig = dig - 3;
          end else if (dig > 9) begin
            bad = 1'b1;
          end
          value = value * 10 + dig;
        end
        if (bad) begin
          r.err = 1'b1;
          r.lat = 2;
        end else if (value > (1 << N) - 1) begin
          r.err = 1'b1;
        end else begin
          r.dout = N'(value);
        end
      end
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("dout", 32'(dout), 32'(e.dout));
        check("err", 32'(err), 32'(e.err));
        check("latency", 32'(cyc - e.cap + 1), 32'(e.lat));
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", 32'(busy), 32'h0);
  endtask

  // Issue one operation; inputs are scrambled after capture to prove they are ignored.
  task automatic run_op(input logic [1:0] s, input logic [4*D-1:0] d);
    wait_idle();
    sel = s;
    din = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sb.push_back(model(s, d, cyc));
    sel = 2'($urandom);
    din = (4*D)'($urandom);
  endtask

  function automatic logic [4*D-1:0] rand_digits(input logic [1:0] s);
    logic [4*D-1:0] d;
    d = '0;
    for (int k = 0; k < D; k++)
      d[4*k +: 4] = (s == 2'b11) ? 4'($urandom_range(3, 12)) : 4'($urandom_range(0, 9));
    return d;
  endfunction

  initial begin
    logic [1:0] s;
    logic [4*D-1:0] d;
    int guard;

    // Reset then idle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_state", 32'(state), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    // Directed vectors.
    run_op(2'b01, 12'h0CA);
    check("busy_after_capture", 32'(busy), 32'h1);
    run_op(2'b10, 12'h255);
    run_op(2'b10, 12'h256);
    run_op(2'b10, 12'h000);
    run_op(2'b11, 12'h45B);
    run_op(2'b11, 12'h42B);
    run_op(2'b00, 12'h0A5);
    run_op(2'b10, 12'h1A3);
    run_op(2'b01, 12'h0FF);
    run_op(2'b11, 12'h333);

    // Start held high: one result every N+3 cycles.
    wait_idle();
    sel = 2'b10;
    din = 12'h099;
    start = 1'b1;
    @(negedge clk);
    sb.push_back(model(2'b10, 12'h099, cyc));
    repeat (2) begin
      repeat (N + 3) @(negedge clk);
      sb.push_back(model(2'b10, 12'h099, cyc));
    end
    start = 1'b0;

    // Reset in the 4th CONV cycle aborts with no done pulse.
    wait_idle();
    check("dout_before_abort", 32'(dout), 32'h63);
    sel = 2'b10;
    din = 12'h099;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_in_conv", 32'(state), 32'h2);
    rst = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_dout", 32'(dout), 32'h0);
    check("abort_err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_idle", 32'(state), 32'h0);

    // Start while busy is ignored.
    run_op(2'b01, 12'h0CA);
    sel = 2'b00;
    din = 12'h055;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      s = 2'($urandom);
      if ($urandom_range(0, 3) == 0) d = (4*D)'($urandom);
      else d = rand_digits(s);
      run_op(s, d);
    end

    // Drain the scoreboard.
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("sb_drain", 32'(sb.size()), 32'h0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
